// File: rtl/accum3_seq.sv
// accum3_seq: 3-bit sequential accumulator over a valid/ready stream, fed through an FA3bit ripple adder.
//   FA3bit     : x, y (3b), c0 -> s (3b), c3
//   accum3_seq : clk, rst (async high), clr (sync), in_valid/in_ready/in_data[2:0],
//                out_valid/out_ready/out_sum[2:0]/out_ovf; N_OPS operands per group.
module FA3bit (
  input  logic [2:0] x,
  input  logic [2:0] y,
  input  logic       c0,
  output logic [2:0] s,
  output logic       c3
);
  logic [3:0] w_c;
  assign w_c[0] = c0;
  genvar i;
  for (i = 0; i < 3; i++) begin : g_fa
    assign s[i]     = x[i] ^ y[i] ^ w_c[i];
    assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
  end
  assign c3 = w_c[3];
endmodule

module accum3_seq #(
  parameter int N_OPS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [2:0] out_sum,
  output logic       out_ovf
);
  typedef enum logic {ACC, HOLD} state_t;
  state_t     r_state;
  logic [2:0] r_acc;
  logic       r_ovf;
  logic [7:0] r_cnt;
  logic [2:0] w_s;
  logic       w_c3;
  FA3bit u_fa (.x(r_acc), .y(in_data), .c0(1'b0), .s(w_s), .c3(w_c3));
  // handshake outputs come from registered state only; clr is deliberately not gated in
  assign in_ready  = (r_state == ACC);
  assign out_valid = (r_state == HOLD);
  assign out_sum   = r_acc;
  assign out_ovf   = r_ovf;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACC;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (clr || (r_state == HOLD && out_ready)) begin
      r_state <= ACC;
      r_acc   <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (r_state == ACC && in_valid) begin
      r_acc   <= w_s;
      r_ovf   <= r_ovf | w_c3;
      r_cnt   <= (r_cnt == 8'(N_OPS - 1)) ? 8'd0 : r_cnt + 8'd1;
      r_state <= (r_cnt == 8'(N_OPS - 1)) ? HOLD : ACC;
    end
  end
endmodule

// File: tb/tb_accum3_seq.sv
// tb_accum3_seq: table vectors, directed corner sequences and random traffic against a group-total model.
module tb_accum3_seq;
  localparam int N = 4;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] in_data = 3'd0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [2:0] out_sum;
  logic       out_ovf;
  int vectors = 0;
  int miscompares = 0;
  accum3_seq #(.N_OPS(N)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  // model: a group is just the integer total of its accepted operands;
  // a carry happened somewhere in the group exactly when that total reached 8
  bit m_hold;
  int m_total;
  int m_cnt;
  function automatic void model_reset();
    m_hold = 0;
    m_total = 0;
    m_cnt = 0;
  endfunction
  function automatic void model_step(bit v, int d, bit r, bit c);
    if (c) model_reset();
    else if (!m_hold && v) begin
      m_total += d;
      m_cnt++;
      if (m_cnt == N) begin
        m_hold = 1;
        m_cnt = 0;
      end
    end else if (m_hold && r) begin
      m_hold = 0;
      m_total = 0;
    end
  endfunction
  task automatic chk(string nm, bit ir, bit ov, int s, bit o);
    vectors++;
    if ({in_ready, out_valid, out_sum, out_ovf} !== {ir, ov, 3'(s), o}) begin
      miscompares++;
      $display("FAIL %s t=%0t got ir=%b ov=%b sum=%0d ovf=%b expected ir=%b ov=%b sum=%0d ovf=%b",
               nm, $time, in_ready, out_valid, out_sum, out_ovf, ir, ov, s % 8, o);
    end
  endtask
  task automatic chk_model(string nm);
    chk(nm, !m_hold, m_hold, m_total % 8, m_total >= 8);
  endtask
  task automatic cyc(bit v, int d, bit r, bit c);
    in_valid = v;
    in_data = 3'(d);
    out_ready = r;
    clr = c;
    @(posedge clk);
    model_step(v, d, r, c);
    #1;
    chk_model("model");
  endtask
  typedef struct {
    bit v; int d; bit r; bit c;
    bit ir; bit ov; int s; bit o;
  } vec_t;
  vec_t tbl[$];
  function automatic void add(bit v, int d, bit r, bit c, bit ir, bit ov, int s, bit o);
    vec_t e;
    e.v = v; e.d = d; e.r = r; e.c = c; e.ir = ir; e.ov = ov; e.s = s; e.o = o;
    tbl.push_back(e);
  endfunction
  initial begin
    model_reset();
    #1;
    chk("reset", 1, 0, 0, 0);
    #2 rst = 1'b0;
    // 1,1,2,3 -> 7 no ovf; 7,7,7,7 -> 4 ovf; 0,0,0,1 -> 1 ovf cleared
    add(1,1,1,0, 1,0,1,0); add(1,1,1,0, 1,0,2,0); add(1,2,1,0, 1,0,4,0); add(1,3,1,0, 0,1,7,0);
    add(0,0,1,0, 1,0,0,0);
    add(1,7,1,0, 1,0,7,0); add(1,7,1,0, 1,0,6,1); add(1,7,1,0, 1,0,5,1); add(1,7,1,0, 0,1,4,1);
    add(1,5,1,0, 1,0,0,0);
    add(1,0,0,0, 1,0,0,0); add(1,0,0,0, 1,0,0,0); add(1,0,0,0, 1,0,0,0); add(1,1,0,0, 0,1,1,0);
    add(0,0,1,0, 1,0,0,0);
    foreach (tbl[k]) begin
      cyc(tbl[k].v, tbl[k].d, tbl[k].r, tbl[k].c);
      chk($sformatf("table%0d", k), tbl[k].ir, tbl[k].ov, tbl[k].s, tbl[k].o);
    end
    // backpressure: 3,3,0,0 held for 5 cycles while upstream offers 5
    cyc(1,3,0,0); cyc(1,3,0,0); cyc(1,0,0,0); cyc(1,0,0,0);
    for (int k = 0; k < 5; k++) begin
      cyc(1,5,0,0);
      chk("bp_hold", 0, 1, 6, 0);
    end
    cyc(0,0,1,0);
    chk("bp_release", 1, 0, 0, 0);
    // gapped 2,2,2,2 with 0..3 idle cycles between operands
    for (int k = 0; k < 4; k++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) cyc(0, 7, 0, 0);
      cyc(1, 2, 0, 0);
    end
    chk("gap_result", 0, 1, 0, 1);
    cyc(0,0,1,0);
    // clr mid-group overrides a simultaneous accept, then 1,1,1,1
    cyc(1,6,0,0); cyc(1,6,0,0);
    cyc(1,6,0,1);
    chk("clr_mid", 1, 0, 0, 0);
    cyc(1,1,0,0); cyc(1,1,0,0); cyc(1,1,0,0); cyc(1,1,0,0);
    chk("clr_group", 0, 1, 4, 0);
    cyc(0,0,1,1);
    chk("clr_hold", 1, 0, 0, 0);
    // async reset between edges after 3 operands
    cyc(1,5,0,0); cyc(1,5,0,0); cyc(1,5,0,0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst", 1, 0, 0, 0);
    #1 rst = 1'b0;
    cyc(1,4,0,0); cyc(1,4,0,0); cyc(1,0,0,0); cyc(1,0,0,0);
    chk("post_rst", 0, 1, 0, 1);
    cyc(0,0,1,0);
    // random traffic
    for (int k = 0; k < 1500; k++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
          $urandom_range(0, 31) == 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/accum3_seq.md
# accum3_seq

Sequential 3-bit accumulator placed directly downstream of the `FA3bit` ripple adder. It accepts a stream of 3-bit operands over a valid/ready handshake and feeds each operand into `FA3bit` together with the running sum. It registers the adder's `s` and `c3` outputs back into the accumulator. After `N_OPS` operands it presents the modulo-8 total plus a sticky overflow flag on a valid/ready output port.

## Interface

- `N_OPS`, default 4: operands per accumulation group; legal range 1..255.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous clear; aborts the current group.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  block can accept an operand.
- `in_data`  in  3  operand.
- `out_valid`  out  1  group result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_sum`  out  3  group total, modulo 8.
- `out_ovf`  out  1  set if any addition in the group produced carry-out.

## Operation

- Internal state: `acc[2:0]`, `ovf`, `cnt[7:0]`, and the FSM state.
- FSM states:
  - `ACC`: accepting operands.
  - `HOLD`: result presented.
- One `FA3bit` instance: `x=acc`, `y=in_data`, `c0=1'b0`; outputs `s` and `c3`. No other adder is used.
- `in_ready` = (state==`ACC`). `out_valid` = (state==`HOLD`). Both are decoded from registered state only.
- Operand accept (`in_valid & in_ready`) in `ACC`:
  - `acc <= s`
  - `ovf <= ovf | c3`
  - If `cnt == N_OPS-1`: go to `HOLD` and set `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
- `HOLD`:
  - `out_sum = acc`, `out_ovf = ovf`, held stable while `out_ready=0`.
  - On `out_valid & out_ready`: go to `ACC` with `acc=0`, `ovf=0`, `cnt=0`.
- `clr=1`: next state `ACC` with `acc=0`, `ovf=0`, `cnt=0`, regardless of state. It overrides a simultaneous operand accept or output handshake, and the dropped result or operand is lost. `in_ready` and `out_valid` still follow the current state in that cycle; `clr` is not combinationally gated into them.
- `in_valid` while `in_ready=0` has no effect; the upstream holds the operand.
- `N_OPS=1`: every accepted operand moves to `HOLD`. Result = operand, `out_ovf=0`.
- Arithmetic wraps modulo 8. `ovf` is sticky within a group and cleared only on result handshake, `clr`, or `rst`.

## Timing

- `rst` asserted (async): state `ACC`, `acc=0`, `ovf=0`, `cnt=0`. Outputs immediately: `in_ready=1`, `out_valid=0`, `out_sum=0`, `out_ovf=0`.
- Reset asserted mid-group or in `HOLD` discards everything. The first edge after deassertion accepts an operand if `in_valid=1`.
- Throughput: one operand per cycle in `ACC`.
- Latency: `out_valid` rises the cycle after the `N_OPS`-th accept edge.
- Minimum `HOLD` residency is 1 cycle; `in_ready=0` for that whole period.
- After the output handshake edge, `in_ready=1` in the next cycle. Minimum group period is `N_OPS+1` cycles.
- There is no combinational path from `in_valid` or `out_ready` to any output.

## Test plan

- Reset, then `N_OPS=4` with operands 1,1,2,3 on consecutive cycles and `out_ready=1` -> `out_valid` for exactly one cycle with `out_sum=3'b111`, `out_ovf=0`; `in_ready` back to 1 the next cycle.
- Operands 7,7,7,7 (partial sums 7,6,5,4) -> `out_sum=3'b100`, `out_ovf=1`. The next group 0,0,0,1 -> `out_sum=3'b001`, `out_ovf=0`, confirming `ovf` was cleared.
- Backpressure: complete group 3,3,0,0, hold `out_ready=0` for 5 cycles with `in_valid=1`, `in_data=5` -> `out_sum=3'b110` stable, `in_ready=0`, no operand absorbed; then `out_ready=1` -> one handshake and return to `ACC`.
- Gapped input: the operands of 2,2,2,2 separated by 0-3 idle cycles -> `out_sum=0`, `out_ovf=1`, and the `cnt` progression is unaffected by idle cycles.
- `clr` after two operands (6,6), then 1,1,1,1 -> `out_sum=3'b100`, `out_ovf=0`. `clr` asserted in `HOLD` -> result dropped, `out_valid=0` next cycle.
- Async `rst` pulse between clock edges in `ACC` after 3 operands -> outputs reset immediately. A following full group 4,4,0,0 -> `out_sum=0`, `out_ovf=1`.
